// File: rtl/fetch_stage_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding instruction-memory
// read at a time and presents fetched instructions to the IF/ID register.
module fetch_stage_unit #(
    parameter int                      CORE         = 0,
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = {ADDRESS_BITS{1'b0}}
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    if_branch,
    input  logic [ADDRESS_BITS-1:0] if_branch_target,
    input  logic [ADDRESS_BITS-1:0] if_JAL_target,
    input  logic [ADDRESS_BITS-1:0] if_JALR_target,
    input  logic [1:0]              if_next_PC_select,
    input  logic                    i_mem_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_data,
    output logic                    i_mem_read,
    output logic [ADDRESS_BITS-1:0] i_mem_address,
    output logic [DATA_WIDTH-1:0]   if_instruction,
    output logic [ADDRESS_BITS-1:0] if_inst_PC,
    output logic                    if_valid
);

    localparam logic [DATA_WIDTH-1:0]   NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_BITS-1:0] PC_STEP   = ADDRESS_BITS'(3'd4);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_WAIT  = 2'b01,
        S_OUT   = 2'b10
    } state_t;

    state_t                  state_r;
    logic [ADDRESS_BITS-1:0] pc_r;
    logic                    squash_r;
    logic [DATA_WIDTH-1:0]   instr_r;
    logic [ADDRESS_BITS-1:0] inst_pc_r;
    logic                    valid_r;

    logic                    redirect_s;
    logic [ADDRESS_BITS-1:0] target_s;

    // Sequential successor; the adder simply wraps at the top of the address space.
    function automatic logic [ADDRESS_BITS-1:0] seq_pc(input logic [ADDRESS_BITS-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // Decode the redirect request returned from decode and pick its target.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = pc_r;
        case (if_next_PC_select)
            2'b01: begin
                redirect_s = if_branch;
                target_s   = if_branch_target;
            end
            2'b10: begin
                redirect_s = 1'b1;
                target_s   = if_JAL_target;
            end
            2'b11: begin
                redirect_s = 1'b1;
                target_s   = if_JALR_target;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = pc_r;
            end
        endcase
    end

    // Fetch FSM: PC, squash tracking and the registered IF/ID-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            squash_r  <= 1'b0;
            instr_r   <= NOP_INSTR;
            inst_pc_r <= RESET_PC;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    // The request issued this cycle stays outstanding even when redirected.
                    state_r <= S_WAIT;
                    if (redirect_s) begin
                        pc_r     <= target_s;
                        squash_r <= 1'b1;
                    end else begin
                        squash_r <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!i_mem_valid) begin
                        if (redirect_s) begin
                            pc_r     <= target_s;
                            squash_r <= 1'b1;
                        end else begin
                            squash_r <= squash_r;
                        end
                    end else if (squash_r || redirect_s) begin
                        squash_r <= 1'b0;
                        state_r  <= S_FETCH;
                        if (redirect_s) begin
                            pc_r <= target_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else begin
                        instr_r   <= i_mem_data;
                        inst_pc_r <= pc_r;
                        valid_r   <= 1'b1;
                        pc_r      <= seq_pc(pc_r);
                        state_r   <= S_OUT;
                    end
                end
                S_OUT: begin
                    // Redirect beats stall; otherwise an unstalled edge consumes the output.
                    if (redirect_s || !stall) begin
                        valid_r <= 1'b0;
                        instr_r <= NOP_INSTR;
                        state_r <= S_FETCH;
                        if (redirect_s) begin
                            pc_r <= target_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else begin
                        state_r <= S_OUT;
                    end
                end
                default: begin
                    state_r  <= S_FETCH;
                    squash_r <= 1'b0;
                    valid_r  <= 1'b0;
                    instr_r  <= NOP_INSTR;
                end
            endcase
        end
    end

    assign i_mem_read     = (state_r == S_FETCH) && !reset;
    assign i_mem_address  = pc_r;
    assign if_instruction = instr_r;
    assign if_inst_PC     = inst_pc_r;
    assign if_valid       = valid_r;

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Bench for fetch_stage_unit: directed vector table, a wrap-around instance,
// and randomized traffic checked against a transaction-level reference model.
module tb_fetch_stage_unit;

    localparam int          AW  = 20;
    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic          if_branch;
    logic [AW-1:0] bt, jt, rt;
    logic [1:0]    sel;
    logic          mv;
    logic [DW-1:0] md;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_address;
    logic [DW-1:0] if_instruction;
    logic [AW-1:0] if_inst_PC;
    logic          if_valid;

    logic          w_read, w_valid, w_mv;
    logic [AW-1:0] w_addr, w_pc;
    logic [DW-1:0] w_instr, w_md;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_stage_unit #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .RESET_PC(20'h00000)) u_dut (
        .clock(clock), .reset(reset), .stall(stall), .if_branch(if_branch),
        .if_branch_target(bt), .if_JAL_target(jt), .if_JALR_target(rt),
        .if_next_PC_select(sel), .i_mem_valid(mv), .i_mem_data(md),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .if_instruction(if_instruction), .if_inst_PC(if_inst_PC), .if_valid(if_valid)
    );

    fetch_stage_unit #(.CORE(1), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .RESET_PC(20'hFFFFC)) u_wrap (
        .clock(clock), .reset(reset), .stall(1'b0), .if_branch(1'b0),
        .if_branch_target(20'h00000), .if_JAL_target(20'h00000), .if_JALR_target(20'h00000),
        .if_next_PC_select(2'b00), .i_mem_valid(w_mv), .i_mem_data(w_md),
        .i_mem_read(w_read), .i_mem_address(w_addr),
        .if_instruction(w_instr), .if_inst_PC(w_pc), .if_valid(w_valid)
    );

    // One-cycle-latency memory for the wrap instance, content mem[a] = a.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_mv <= 1'b0;
            w_md <= 32'h0;
        end else begin
            w_mv <= w_read;
            w_md <= {12'h000, w_addr};
        end
    end

    typedef struct {
        logic          rst, stl, br, v, xr, xv;
        logic [1:0]    s;
        logic [AW-1:0] t, xa, xp;
        logic [31:0]   d, xi;
    } vec_t;

    vec_t tbl[34];

    function automatic vec_t mk(input int rst, input int stl, input int s, input int b, input int t,
                                input int v, input int d, input int xr, input int xa, input int xv,
                                input int xi, input int xp);
        vec_t r;
        r.rst = rst[0]; r.stl = stl[0]; r.s = s[1:0]; r.br = b[0]; r.t = t[AW-1:0];
        r.v = v[0]; r.d = d; r.xr = xr[0]; r.xa = xa[AW-1:0]; r.xv = xv[0];
        r.xi = xi; r.xp = xp[AW-1:0];
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a[11:0], a} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [AW-1:0] rnd_tgt();
        logic [AW-1:0] t;
        t = AW'($urandom);
        t[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) t = 20'hFFFFC;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic xr, input logic [AW-1:0] xa,
                                 input logic xv, input logic [31:0] xi, input logic [AW-1:0] xp);
        chk({tag, " i_mem_read"}, {31'd0, i_mem_read}, {31'd0, xr});
        chk({tag, " i_mem_address"}, {12'd0, i_mem_address}, {12'd0, xa});
        chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, xv});
        chk({tag, " if_instruction"}, if_instruction, xi);
        chk({tag, " if_inst_PC"}, {12'd0, if_inst_PC}, {12'd0, xp});
    endtask

    // Reference model state: next fetch address, request/presentation bookkeeping.
    logic [AW-1:0] m_pc, m_out_pc, mem_addr, tgt;
    logic [31:0]   m_out_data;
    logic          m_pend, m_doom, m_show, mem_busy, redir, r_rst;
    int            mem_left, pick, nreq;
    logic [AW-1:0] req_addr[2];

    initial begin
        reset = 1'b1; stall = 1'b0; if_branch = 1'b0; sel = 2'b00;
        bt = 20'h0; jt = 20'h0; rt = 20'h0; mv = 1'b0; md = 32'h0;

        // k=1, plain memory, stall, JAL in WAIT, branch not-taken / taken, reset in WAIT.
        tbl[0]  = mk(1,0,0,0,'h0,  0,'h0,   0,'h0,  0,'h13,'h0);
        tbl[1]  = mk(0,0,0,0,'h0,  0,'h0,   1,'h0,  0,'h13,'h0);
        tbl[2]  = mk(0,0,0,0,'h0,  1,'h0,   0,'h0,  0,'h13,'h0);
        tbl[3]  = mk(0,0,0,0,'h0,  0,'h0,   0,'h4,  1,'h0, 'h0);
        tbl[4]  = mk(0,0,0,0,'h0,  0,'h0,   1,'h4,  0,'h13,'h0);
        tbl[5]  = mk(0,0,0,0,'h0,  1,'h4,   0,'h4,  0,'h13,'h0);
        tbl[6]  = mk(0,1,0,0,'h0,  0,'h0,   0,'h8,  1,'h4, 'h4);
        tbl[7]  = mk(0,1,0,0,'h0,  0,'h0,   0,'h8,  1,'h4, 'h4);
        tbl[8]  = mk(0,1,0,0,'h0,  0,'h0,   0,'h8,  1,'h4, 'h4);
        tbl[9]  = mk(0,1,0,0,'h0,  0,'h0,   0,'h8,  1,'h4, 'h4);
        tbl[10] = mk(0,0,0,0,'h0,  0,'h0,   0,'h8,  1,'h4, 'h4);
        tbl[11] = mk(0,0,0,0,'h0,  0,'h0,   1,'h8,  0,'h13,'h4);
        tbl[12] = mk(0,0,2,0,'h100,0,'h0,   0,'h8,  0,'h13,'h4);
        tbl[13] = mk(0,0,0,0,'h0,  0,'h0,   0,'h100,0,'h13,'h4);
        tbl[14] = mk(0,0,0,0,'h0,  1,'h8,   0,'h100,0,'h13,'h4);
        tbl[15] = mk(0,0,0,0,'h0,  0,'h0,   1,'h100,0,'h13,'h4);
        tbl[16] = mk(0,0,0,0,'h0,  1,'h100, 0,'h100,0,'h13,'h4);
        tbl[17] = mk(0,0,1,0,'h40, 0,'h0,   0,'h104,1,'h100,'h100);
        tbl[18] = mk(0,0,1,0,'h40, 0,'h0,   1,'h104,0,'h13,'h100);
        tbl[19] = mk(0,0,1,0,'h40, 1,'h104, 0,'h104,0,'h13,'h100);
        tbl[20] = mk(0,0,1,1,'h40, 0,'h0,   0,'h108,1,'h104,'h104);
        tbl[21] = mk(0,0,0,0,'h0,  0,'h0,   1,'h40, 0,'h13,'h104);
        tbl[22] = mk(1,0,0,0,'h0,  0,'h0,   0,'h40, 0,'h13,'h104);
        tbl[23] = mk(0,0,0,0,'h0,  0,'h0,   1,'h0,  0,'h13,'h0);
        tbl[24] = mk(0,0,0,0,'h0,  1,'h0,   0,'h0,  0,'h13,'h0);
        // JALR with stall in OUT, redirect in FETCH, re-redirect while squashed, redirect with valid.
        tbl[25] = mk(0,1,3,0,'h200,0,'h0,   0,'h4,  1,'h0, 'h0);
        tbl[26] = mk(0,0,2,0,'h300,0,'h0,   1,'h200,0,'h13,'h0);
        tbl[27] = mk(0,0,3,0,'h500,0,'h0,   0,'h300,0,'h13,'h0);
        tbl[28] = mk(0,0,0,0,'h0,  1,'h200, 0,'h500,0,'h13,'h0);
        tbl[29] = mk(0,0,0,0,'h0,  0,'h0,   1,'h500,0,'h13,'h0);
        tbl[30] = mk(0,0,1,1,'h600,1,'h500, 0,'h500,0,'h13,'h0);
        tbl[31] = mk(0,0,0,0,'h0,  0,'h0,   1,'h600,0,'h13,'h0);
        tbl[32] = mk(0,0,0,0,'h0,  1,'h600, 0,'h600,0,'h13,'h0);
        tbl[33] = mk(0,0,0,0,'h0,  0,'h0,   0,'h604,1,'h600,'h600);

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Wrap instance: RESET_PC 0xFFFFC, second request must be at 0x00000.
        nreq = 0;
        for (int c = 0; c < 20 && nreq < 2; c++) begin
            #1;
            if (w_read) begin
                req_addr[nreq] = w_addr;
                nreq++;
            end
            if (w_valid) begin
                chk("wrap instr", w_instr, 32'h000F_FFFC);
                chk("wrap inst_PC", {12'd0, w_pc}, 32'h000F_FFFC);
            end
            @(negedge clock);
        end
        chk("wrap request count", nreq, 2);
        if (nreq == 2) begin
            chk("wrap first request", {12'd0, req_addr[0]}, 32'h000F_FFFC);
            chk("wrap second request", {12'd0, req_addr[1]}, 32'h0000_0000);
        end

        reset = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 34; i++) begin
            @(negedge clock);
            reset     = tbl[i].rst;
            stall     = tbl[i].stl;
            sel       = tbl[i].s;
            if_branch = tbl[i].br;
            bt        = (tbl[i].s == 2'b01) ? tbl[i].t : 20'h0AAA0;
            jt        = (tbl[i].s == 2'b10) ? tbl[i].t : 20'h0BBB0;
            rt        = (tbl[i].s == 2'b11) ? tbl[i].t : 20'h0CCC0;
            mv        = tbl[i].v;
            md        = tbl[i].d;
            #1;
            check_outputs($sformatf("vec%0d", i), tbl[i].xr, tbl[i].xa, tbl[i].xv, tbl[i].xi, tbl[i].xp);
        end

        // Randomized traffic against the reference model.
        @(negedge clock);
        reset = 1'b1; stall = 1'b0; sel = 2'b00; if_branch = 1'b0; mv = 1'b0;
        @(posedge clock);
        m_pc = 20'h0; m_out_pc = 20'h0; m_out_data = NOP;
        m_pend = 1'b0; m_doom = 1'b0; m_show = 1'b0; mem_busy = 1'b0; mem_left = 0;
        mem_addr = 20'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            r_rst = ($urandom_range(0, 249) == 0);
            stall = ($urandom_range(0, 9) < 4);
            pick  = $urandom_range(0, 19);
            if_branch = 1'($urandom);
            if (pick == 0) begin
                sel = 2'b01; if_branch = 1'b1;
            end else if (pick == 1) begin
                sel = 2'b10;
            end else if (pick == 2) begin
                sel = 2'b11;
            end else if (pick < 6) begin
                sel = 2'b01; if_branch = 1'b0;
            end else begin
                sel = 2'b00;
            end
            bt = rnd_tgt(); jt = rnd_tgt(); rt = rnd_tgt();
            mv = 1'b0;
            md = $urandom;
            if (mem_busy) begin
                mem_left--;
                if (mem_left == 0) begin
                    mv = 1'b1;
                    md = mem_word(mem_addr);
                    mem_busy = 1'b0;
                end
            end
            reset = r_rst;
            #1;
            check_outputs("rnd", !m_pend && !m_show && !r_rst, m_pc, m_show, m_out_data, m_out_pc);

            if (r_rst) begin
                mem_busy = 1'b0;
            end else if (i_mem_read) begin
                mem_busy = 1'b1;
                mem_addr = i_mem_address;
                mem_left = $urandom_range(1, 4);
            end

            redir = (sel == 2'b01 && if_branch) || sel[1];
            tgt   = (sel == 2'b01) ? bt : (sel == 2'b10) ? jt : rt;
            if (r_rst) begin
                m_pc = 20'h0; m_out_pc = 20'h0; m_out_data = NOP;
                m_pend = 1'b0; m_doom = 1'b0; m_show = 1'b0;
            end else if (m_show) begin
                if (redir || !stall) begin
                    m_show = 1'b0;
                    m_out_data = NOP;
                end
                if (redir) m_pc = tgt;
            end else if (m_pend) begin
                if (mv) begin
                    m_pend = 1'b0;
                    if (m_doom || redir) begin
                        m_doom = 1'b0;
                        if (redir) m_pc = tgt;
                    end else begin
                        m_show = 1'b1;
                        m_out_data = md;
                        m_out_pc = m_pc;
                        m_pc = m_pc + 20'd4;
                    end
                end else if (redir) begin
                    m_pc = tgt;
                    m_doom = 1'b1;
                end
            end else begin
                m_pend = 1'b1;
                m_doom = redir;
                if (redir) m_pc = tgt;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
